// File: rtl/event_sequencer_pkg.sv
// Shared constants and parameter checks for the event sequencer and its
// debounce channels.
package event_seq_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEB_CYCLES_DEF  = 16;
    localparam int DEB_W_DEF       = 8;

    // True when a DEB_W-bit counter can reach DEB_CYCLES-1.
    function automatic logic deb_width_ok(input int deb_w, input int deb_cycles);
        return ((64'(1) << deb_w) >= 64'(deb_cycles));
    endfunction

endpackage

// File: rtl/event_sequencer_debounce.sv
// One event channel: synchroniser chain, level debouncer and a one-cycle
// pulse on the edge where the stable level goes 0->1.
module debounce_chan
    import event_seq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int DEB_W       = DEB_W_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic evt_i,
    output logic rise_o
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_q, lvl_d;
    logic [DEB_W-1:0]       cnt_q, cnt_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Next-state for synchroniser, stable level and debounce counter.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], evt_i};
        lvl_d  = lvl_q;
        cnt_d  = '0;
        rise_o = 1'b0;
        if (sync_s == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            lvl_d  = sync_s;
            cnt_d  = '0;
            rise_o = sync_s;
        end else begin
            cnt_d = cnt_q + DEB_W'(1);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/event_sequencer.sv
// Serialises debounced rising edges on two event inputs into single-cycle
// issue strobes, tracking pending requests and lost ones.
module event_sequencer
    import event_seq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int DEB_W       = DEB_W_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Evt0,
    input  logic       Evt1,
    input  logic       Clr_drop,
    output logic       En,
    output logic       Slt,
    output logic [1:0] Pend,
    output logic       Drop
);

    if (!deb_width_ok(DEB_W, DEB_CYCLES)) begin : g_bad_deb_w
        $error("DEB_W too narrow for DEB_CYCLES");
    end

    logic [1:0] rise_s;
    logic [1:0] grant_s;
    logic [1:0] pend_q, pend_d;
    logic       last_q, last_d;
    logic       en_q, en_d;
    logic       slt_q, slt_d;
    logic       drop_q, drop_d;

    debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_chan0 (
        .clk_i (Clk),
        .rst_ni(Reset),
        .evt_i (Evt0),
        .rise_o(rise_s[0])
    );

    debounce_chan #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_chan1 (
        .clk_i (Clk),
        .rst_ni(Reset),
        .evt_i (Evt1),
        .rise_o(rise_s[1])
    );

    // Arbitration, pending bookkeeping and drop detection.
    always_comb begin
        grant_s = 2'b00;
        en_d    = 1'b0;
        slt_d   = slt_q;
        last_d  = last_q;
        case (pend_q)
            2'b01: begin
                grant_s = 2'b01;
                en_d    = 1'b1;
                slt_d   = CH0;
            end
            2'b10: begin
                grant_s = 2'b10;
                en_d    = 1'b1;
                slt_d   = CH1;
            end
            2'b11: begin
                en_d = 1'b1;
                // The pointer only moves on contended grants.
                if (last_q == CH1) begin
                    grant_s = 2'b01;
                    slt_d   = CH0;
                    last_d  = CH0;
                end else begin
                    grant_s = 2'b10;
                    slt_d   = CH1;
                    last_d  = CH1;
                end
            end
            default: begin
                grant_s = 2'b00;
            end
        endcase
        pend_d = (pend_q & ~grant_s) | rise_s;
        drop_d = (drop_q & ~Clr_drop) | (|(rise_s & pend_q & ~grant_s));
    end

    // Issue, pending and drop registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pend_q <= 2'b00;
            last_q <= CH1;
            en_q   <= 1'b0;
            slt_q  <= CH0;
            drop_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            last_q <= last_d;
            en_q   <= en_d;
            slt_q  <= slt_d;
            drop_q <= drop_d;
        end
    end

    assign En   = en_q;
    assign Slt  = slt_q;
    assign Pend = pend_q;
    assign Drop = drop_q;

endmodule

// File: tb/tb_event_sequencer.sv
// Directed bench for event_sequencer with SYNC_STAGES=2, DEB_CYCLES=4.
module tb_event_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Evt0;
    logic       Evt1;
    logic       Clr_drop;
    logic       En;
    logic       Slt;
    logic [1:0] Pend;
    logic       Drop;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst_n;
        logic       e0;
        logic       e1;
        logic       clr;
        logic       en;
        logic       slt;
        logic [1:0] pend;
        logic       drop;
    } vec_t;

    vec_t vecs[$];

    event_sequencer #(.SYNC_STAGES(2), .DEB_CYCLES(4), .DEB_W(8)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Evt0    (Evt0),
        .Evt1    (Evt1),
        .Clr_drop(Clr_drop),
        .En      (En),
        .Slt     (Slt),
        .Pend    (Pend),
        .Drop    (Drop)
    );

    always #5 Clk = ~Clk;

    task automatic add_n(input int n, input logic rst_n, input logic e0, input logic e1,
                         input logic clr, input logic en, input logic slt,
                         input logic [1:0] pend, input logic drop);
        vec_t v;
        v.rst_n = rst_n; v.e0 = e0; v.e1 = e1; v.clr = clr;
        v.en = en; v.slt = slt; v.pend = pend; v.drop = drop;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic cmp(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    initial begin
        Reset = 1'b0; Evt0 = 1'b0; Evt1 = 1'b0; Clr_drop = 1'b0;

        // fields: count, Reset, Evt0, Evt1, Clr_drop | En, Slt, Pend, Drop
        add_n(2, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        // 1: Evt0 held high, latency 7
        add_n(5, 1, 1, 0, 0, 0, 0, 2'b00, 0);
        add_n(1, 1, 1, 0, 0, 0, 0, 2'b01, 0);
        add_n(1, 1, 1, 0, 0, 1, 0, 2'b00, 0);
        add_n(1, 1, 1, 0, 0, 0, 0, 2'b00, 0);
        add_n(8, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        // 2: 3-cycle glitch ignored, then 8-cycle pulse
        add_n(3, 1, 0, 1, 0, 0, 0, 2'b00, 0);
        add_n(5, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        add_n(5, 1, 0, 1, 0, 0, 0, 2'b00, 0);
        add_n(1, 1, 0, 1, 0, 0, 0, 2'b10, 0);
        add_n(1, 1, 0, 1, 0, 1, 1, 2'b00, 0);
        add_n(1, 1, 0, 1, 0, 0, 1, 2'b00, 0);
        add_n(8, 1, 0, 0, 0, 0, 1, 2'b00, 0);
        // 5: reset while both pending
        add_n(5, 1, 1, 1, 0, 0, 1, 2'b00, 0);
        add_n(1, 1, 1, 1, 0, 0, 1, 2'b11, 0);
        add_n(1, 0, 1, 1, 0, 0, 0, 2'b00, 0);
        add_n(10, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        // 3: tie after reset, ch0 first
        add_n(5, 1, 1, 1, 0, 0, 0, 2'b00, 0);
        add_n(1, 1, 1, 1, 0, 0, 0, 2'b11, 0);
        add_n(1, 1, 1, 1, 0, 1, 0, 2'b10, 0);
        add_n(1, 1, 1, 1, 0, 1, 1, 2'b00, 0);
        add_n(8, 1, 0, 0, 0, 0, 1, 2'b00, 0);
        // 3: repeated tie, ch1 first
        add_n(5, 1, 1, 1, 0, 0, 1, 2'b00, 0);
        add_n(1, 1, 1, 1, 0, 0, 1, 2'b11, 0);
        add_n(1, 1, 1, 1, 0, 1, 1, 2'b01, 0);
        add_n(1, 1, 1, 1, 0, 1, 0, 2'b00, 0);
        add_n(8, 1, 0, 0, 0, 0, 0, 2'b00, 0);

        foreach (vecs[k]) begin
            Reset = vecs[k].rst_n; Evt0 = vecs[k].e0;
            Evt1 = vecs[k].e1; Clr_drop = vecs[k].clr;
            tick();
            cmp($sformatf("vec%0d {En,Slt,Pend,Drop}", k), {En, Slt, Pend, Drop},
                {vecs[k].en, vecs[k].slt, vecs[k].pend, vecs[k].drop});
        end

        // 4: ch0 pending and starved by ch1 wins, second ch0 rise is dropped
        force dut.pend_q = 2'b11;
        force dut.last_q = 1'b0;
        Evt0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            cmp($sformatf("t4 starve edge%0d", i), {En, Slt, Pend, Drop}, 5'b1_1_11_0);
        end
        tick();
        cmp("t4 drop set", {En, Slt, Pend, Drop}, 5'b1_1_11_1);
        release dut.pend_q;
        release dut.last_q;
        Clr_drop = 1'b1;
        tick();
        cmp("t4 drop cleared", {4'b0000, Drop}, 5'b0_0_00_0);
        Clr_drop = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        cmp("t4 drained", {En, 1'b0, Pend, Drop}, 5'b0_0_00_0);
        Evt0 = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // 6: clear on the same edge as a new drop keeps Drop set
        force dut.pend_q = 2'b11;
        force dut.last_q = 1'b0;
        Evt0 = 1'b1;
        Clr_drop = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        cmp("t6 before drop", {4'b0000, Drop}, 5'b0_0_00_0);
        tick();
        cmp("t6 clr+drop same edge", {4'b0000, Drop}, 5'b0_0_00_1);
        tick();
        cmp("t6 clr after drop", {4'b0000, Drop}, 5'b0_0_00_0);
        release dut.pend_q;
        release dut.last_q;
        Clr_drop = 1'b0;
        Evt0 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        cmp("t6 idle", {En, 1'b0, Pend, Drop}, 5'b0_0_00_0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
